// File: rtl/uart_host_init.sv
// UART host bridge: sends a preamble, address and optional write data as UART frames,
// then collects a 4-byte read response with parity, framing and timeout checking.
module uart_host_init #(
  parameter logic [7:0] PRE_RD = 8'h4D,
  parameter logic [7:0] PRE_WR = 8'h34
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [31:0] baud_div,
  input  logic        par_en,
  input  logic        par_even,
  input  logic [31:0] rsp_timeout,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        TX,
  input  logic        RX
);
  localparam int unsigned DW = 32;
  localparam int unsigned BIW = 4;

  typedef enum logic [2:0] {IDLE, TX_PRE, TX_ADDR, TX_WDATA, RX_RDATA, RSP} state_t;

  state_t          state, state_nxt;
  logic [DW-1:0]   cnt, cnt_nxt;
  logic [BIW-1:0]  bit_idx, bit_nxt;
  logic [1:0]      byte_cnt, byte_nxt;
  logic            lat_write, lat_par_en, lat_par_even;
  logic [DW-1:0]   lat_addr, lat_wdata, lat_div, lat_tmo;
  logic            rx_s1, rx_s2;
  logic            rx_busy, rx_busy_nxt;
  logic [DW-1:0]   rx_cnt, rx_cnt_nxt;
  logic [BIW-1:0]  rx_bit, rx_bit_nxt;
  logic [7:0]      rx_shift, rx_shift_nxt;
  logic [1:0]      rx_bytes, rx_bytes_nxt;
  logic [DW-1:0]   rx_data, rx_data_nxt;
  logic [DW-1:0]   tmo_cnt, tmo_nxt;
  logic            rx_done_c, rx_err_c, armed_c, accept_c, tx_nxt;
  logic [BIW-1:0]  last_bit_c;
  logic [7:0]      tx_byte_c;

  function automatic logic tx_bit_f(input logic [7:0] b, input logic [BIW-1:0] idx,
                                    input logic pen, input logic peven);
    if (idx == 4'd0)                   return 1'b0;
    else if (idx <= 4'd8)              return b[3'(idx - 4'd1)];
    else if (idx == 4'd9 && pen)       return (^b) ^ ~peven;
    else                               return 1'b1;
  endfunction

  assign accept_c   = (state == IDLE) && cmd_valid;
  assign last_bit_c = lat_par_en ? 4'd10 : 4'd9;
  // Receiver listens from the first cycle of the last address stop bit on reads.
  assign armed_c    = (state == RX_RDATA) ||
                      (state == TX_ADDR && !lat_write && byte_cnt == 2'd3 && bit_idx == last_bit_c);

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    bit_nxt      = bit_idx;
    byte_nxt     = byte_cnt;
    rx_busy_nxt  = rx_busy;
    rx_cnt_nxt   = rx_cnt;
    rx_bit_nxt   = rx_bit;
    rx_shift_nxt = rx_shift;
    rx_bytes_nxt = rx_bytes;
    rx_data_nxt  = rx_data;
    tmo_nxt      = tmo_cnt;
    rx_done_c    = 1'b0;
    rx_err_c     = 1'b0;
    tx_byte_c    = '0;
    tx_nxt       = 1'b1;

    // Receiver: start detect with glitch re-check, mid-bit sampling, timeout while idle.
    if (!armed_c) begin
      rx_busy_nxt = 1'b0;
      tmo_nxt     = '0;
    end else if (!rx_busy) begin
      if (!rx_s2) begin
        rx_busy_nxt = 1'b1;
        rx_cnt_nxt  = lat_div >> 1;
        rx_bit_nxt  = '0;
        tmo_nxt     = '0;
      end else if (lat_tmo != '0 && DW'(tmo_cnt + 32'd1) == lat_tmo) begin
        rx_err_c = 1'b1;
      end else begin
        tmo_nxt = DW'(tmo_cnt + 32'd1);
      end
    end else if (rx_cnt != '0) begin
      rx_cnt_nxt = DW'(rx_cnt - 32'd1);
    end else begin
      rx_cnt_nxt = lat_div;
      if (rx_bit == 4'd0) begin
        if (rx_s2) rx_busy_nxt = 1'b0;
        else       rx_bit_nxt  = 4'd1;
      end else if (rx_bit <= 4'd8) begin
        rx_shift_nxt = {rx_s2, rx_shift[7:1]};
        rx_bit_nxt   = BIW'(rx_bit + 4'd1);
      end else if (rx_bit == 4'd9 && lat_par_en) begin
        if (((^rx_shift) ^ rx_s2) != ~lat_par_even) rx_err_c = 1'b1;
        else rx_bit_nxt = 4'd10;
      end else if (!rx_s2) begin
        rx_err_c = 1'b1;
      end else begin
        rx_data_nxt[{rx_bytes, 3'b000} +: 8] = rx_shift;
        rx_busy_nxt  = 1'b0;
        tmo_nxt      = '0;
        rx_bytes_nxt = 2'(rx_bytes + 2'd1);
        if (rx_bytes == 2'd3) rx_done_c = 1'b1;
      end
    end

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_nxt    = TX_PRE;
          cnt_nxt      = '0;
          bit_nxt      = '0;
          byte_nxt     = '0;
          rx_bytes_nxt = '0;
          rx_data_nxt  = '0;
        end
      end
      TX_PRE, TX_ADDR, TX_WDATA: begin
        if (cnt == lat_div) begin
          cnt_nxt = '0;
          if (bit_idx == last_bit_c) begin
            bit_nxt  = '0;
            byte_nxt = 2'(byte_cnt + 2'd1);
            if (state == TX_PRE) begin
              state_nxt = TX_ADDR;
              byte_nxt  = '0;
            end else if (byte_cnt == 2'd3) begin
              if (state == TX_WDATA) state_nxt = RSP;
              else if (lat_write)    state_nxt = TX_WDATA;
              else                   state_nxt = RX_RDATA;
            end
          end else begin
            bit_nxt = BIW'(bit_idx + 4'd1);
          end
        end else begin
          cnt_nxt = DW'(cnt + 32'd1);
        end
        if (rx_done_c || rx_err_c) state_nxt = RSP;
      end
      RX_RDATA: if (rx_done_c || rx_err_c) state_nxt = RSP;
      RSP:      state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase

    case (state_nxt)
      TX_PRE:   tx_byte_c = lat_write ? PRE_WR : PRE_RD;
      TX_ADDR:  tx_byte_c = lat_addr[{byte_nxt, 3'b000} +: 8];
      TX_WDATA: tx_byte_c = lat_wdata[{byte_nxt, 3'b000} +: 8];
      default:  tx_byte_c = '0;
    endcase
    if (state_nxt == TX_PRE || state_nxt == TX_ADDR || state_nxt == TX_WDATA)
      tx_nxt = tx_bit_f(tx_byte_c, bit_nxt, lat_par_en, lat_par_even);
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      byte_cnt     <= '0;
      lat_write    <= 1'b0;
      lat_par_en   <= 1'b0;
      lat_par_even <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      lat_div      <= '0;
      lat_tmo      <= '0;
      rx_s1        <= 1'b1;
      rx_s2        <= 1'b1;
      rx_busy      <= 1'b0;
      rx_cnt       <= '0;
      rx_bit       <= '0;
      rx_shift     <= '0;
      rx_bytes     <= '0;
      rx_data      <= '0;
      tmo_cnt      <= '0;
      TX           <= 1'b1;
      cmd_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_err      <= 1'b0;
      rsp_rdata    <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bit_idx   <= bit_nxt;
      byte_cnt  <= byte_nxt;
      if (accept_c) begin
        lat_write    <= cmd_write;
        lat_par_en   <= par_en;
        lat_par_even <= par_even;
        lat_addr     <= cmd_addr;
        lat_wdata    <= cmd_wdata;
        lat_div      <= (baud_div == '0) ? 32'd1 : baud_div;
        lat_tmo      <= rsp_timeout;
      end
      rx_s1     <= RX;
      rx_s2     <= rx_s1;
      rx_busy   <= rx_busy_nxt;
      rx_cnt    <= rx_cnt_nxt;
      rx_bit    <= rx_bit_nxt;
      rx_shift  <= rx_shift_nxt;
      rx_bytes  <= rx_bytes_nxt;
      rx_data   <= rx_data_nxt;
      tmo_cnt   <= tmo_nxt;
      TX        <= tx_nxt;
      cmd_ready <= (state_nxt == IDLE);
      rsp_valid <= (state_nxt == RSP);
      rsp_err   <= (state_nxt == RSP) && rx_err_c;
      rsp_rdata <= (state_nxt == RSP) ? rx_data_nxt : '0;
    end
  end

endmodule

// File: doc/uart_host_init.md
UART_HOST_INIT -- requirements
Module: uart_host_init

Interface
REQ-001 Parameters SHALL be: PRE_RD, 8'h4D, read preamble byte; PRE_WR, 8'h34, write preamble byte.
REQ-002 Clock and reset SHALL be hresetn, asynchronous, active-low; clock hclk.
REQ-003 hclk  in  1  system clock.
REQ-004 hresetn  in  1  asynchronous active-low reset.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_ready  out  1  block idle, command accepted when cmd_valid&cmd_ready.
REQ-007 cmd_write  in  1  1=write, 0=read.
REQ-008 cmd_addr  in  32  target address.
REQ-009 cmd_wdata  in  32  write data (ignored for reads).
REQ-010 baud_div  in  32  bit period minus one, in hclk cycles.
REQ-011 par_en  in  1  parity bit enabled.
REQ-012 par_even  in  1  1=even parity, 0=odd parity.
REQ-013 rsp_timeout  in  32  read-response inter-byte timeout, hclk cycles.
REQ-014 rsp_valid  out  1  one-cycle completion pulse.
REQ-015 rsp_rdata  out  32  read data, valid with rsp_valid.
REQ-016 rsp_err  out  1  parity/framing/timeout error, valid with rsp_valid.
REQ-017 TX  out  1  serial output to target.
REQ-018 RX  in  1  serial input from target.

Function
REQ-019 Frame: start bit (0), 8 data bits LSB first, parity bit if par_en, one stop bit (1); each bit SHALL last exactly baud_div+1 hclk cycles; baud_div=0 SHALL behave as 1.
REQ-020 Parity bit SHALL make the count of ones over data+parity even when par_even=1, odd when par_even=0.
REQ-021 cmd_addr, cmd_wdata, cmd_write, baud_div, par_en, par_even, rsp_timeout SHALL be latched at acceptance; later input changes have no effect until the next command.
REQ-022 FSM states: IDLE, TX_PRE, TX_ADDR, TX_WDATA, RX_RDATA, RSP; cmd_ready=1 only in IDLE.
REQ-023 Acceptance SHALL move IDLE->TX_PRE; TX SHALL drive the start bit on the cycle after acceptance.
REQ-024 TX_PRE sends PRE_WR or PRE_RD, then TX_ADDR sends 4 address bytes LSB byte first; write continues to TX_WDATA (4 data bytes LSB first), read to RX_RDATA.
REQ-025 Consecutive frames SHALL be back-to-back with no idle bits between stop and next start.
REQ-026 Write completion: RSP entered on the cycle after the last stop bit ends; rsp_valid=1, rsp_err=0, rsp_rdata=0 for one cycle, then IDLE.
REQ-027 Receiver SHALL pass RX through a 2-flop synchronizer (reset value 1) and be armed from the first cycle of the last address byte's stop bit until 4 bytes received or error.
REQ-028 Start detect: synchronized RX low while armed and idle; re-check at (baud_div>>1) cycles, abort silently (glitch) if high; then sample each subsequent bit every baud_div+1 cycles.
REQ-029 Received bytes SHALL assemble into rsp_rdata LSB byte first; after the 4th stop bit sample, RSP with rsp_err=0.
REQ-030 Parity mismatch or stop bit sampled 0 SHALL end reception immediately: RSP with rsp_err=1, rsp_rdata holding bytes received so far (unreceived bytes 0).
REQ-031 Timeout counter SHALL restart on arming and after each received stop bit; reaching rsp_timeout without a start detect SHALL give RSP with rsp_err=1; rsp_timeout=0 disables timeout.
REQ-032 RX activity outside the armed window SHALL be ignored; TX SHALL stay 1 outside frames.
REQ-033 cmd_valid asserted during RSP SHALL not be accepted until IDLE (one cycle later).

Reset
REQ-034 On hresetn low, at any point including mid-frame: TX=1, cmd_ready=1 after release, rsp_valid=0, rsp_err=0, rsp_rdata=0, FSM=IDLE, all counters 0, receiver disarmed.

Verification
REQ-035 baud_div=9, par_en=0, write addr 0x12345678 data 0xAABBCCDD -> TX frames 34,78,56,34,12,DD,CC,BB,AA, 100 cycles each, rsp_valid (err=0) at cycle 901 after acceptance.
REQ-036 baud_div=9, read addr 0x00000040, bench returns 11,22,33,44 -> TX frames 4D,40,00,00,00; rsp_rdata=0x44332211, rsp_err=0.
REQ-037 par_en=1, par_even=1, write preamble 0x34 -> 11-bit frame, parity bit 1; par_even=0 -> parity bit 0.
REQ-038 Read, rsp_timeout=1000, RX held 1 -> rsp_valid with rsp_err=1 exactly 1000 cycles after arming; read with 2nd response byte stop bit 0 -> rsp_err=1, rsp_rdata=0x00000011.
REQ-039 hresetn pulsed during 3rd address frame -> TX=1 next cycle, no rsp_valid, new command afterward completes normally.
